matrix_out_streamer: RTL and testbench
======================================

Name: matrix_out_streamer

Overview:
Downstream stage of the output register. On a start pulse it requests a read of the stored 4x4 matrix, captures the 256-bit word, and streams the 16 elements out one per transfer over a 16-bit valid/ready interface, in row-major order. It is the path from the matrix result store to the external output bus and the testbench monitor.

Parameters:
ELEM_W, 16, bits per matrix element
DIM, 4, matrix is DIM x DIM; MAT_W = ELEM_W*DIM*DIM = 256

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to stream the current output-register contents
reg_read  output  1  read strobe to the output register (drives its read_data input)
reg_data  input  MAT_W  matrix word from the output register; element k is at bits [16k+15:16k]
out_data  output  ELEM_W  current element
out_valid  output  1  out_data holds a valid element
out_ready  input  1  consumer accepts out_data when high together with out_valid
out_last  output  1  high with out_valid on element 15
out_row  output  2  row index of the current element (k/4)
out_col  output  2  column index of the current element (k%4)
busy  output  1  high from the cycle after start is accepted until the cycle done is asserted
done  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset is asynchronous: clk is reset, reset is asynchronous and active-high. All outputs are 0, the state is IDLE, the element counter is 0 and the capture buffer is 0. Reset asserted mid-stream aborts immediately. No done pulse is generated and no further reg_read is issued.
- States:
  - IDLE: start high at edge N moves to FETCH. reg_read=1 and busy=1 during cycle N..N+1.
  - FETCH: reg_read is high for exactly one cycle. The next edge moves to WAIT with reg_read=0. This gives the output register's read a full cycle to update its data.
  - WAIT: at the next edge, buf <= reg_data, k <= 0, and the state moves to STREAM. out_valid rises here, so latency from start to the first valid is 3 edges.
  - STREAM: out_data = buf[16k+15:16k]. out_row = k[3:2] and out_col = k[1:0]. out_last = (k==15).
    - On an edge with out_valid && out_ready and k<15: k <= k+1.
    - On an edge with out_valid && out_ready and k==15: out_valid <= 0, done <= 1 for one cycle, busy <= 0, and the state moves to IDLE.
  - out_valid is only ever 1 in STREAM.
- Handshake: while out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last are held stable. out_valid never drops without a transfer.
- out_ready is ignored while out_valid=0.
- start is ignored whenever busy=1, including in the same cycle as done. start in the cycle after done is accepted.
- reg_data is sampled only at the WAIT->STREAM edge. Changes to the output register contents during STREAM do not affect the elements being streamed.
- Maximum throughput is one element per cycle. A full stream with out_ready held high takes 3 + 16 cycles from start to done.
- The counter k is 4 bits and never wraps past 15 within a stream.

Decomposition:
- Shared package matrix_pkg holds ELEM_W, DIM, MAT_W, the state encoding (IDLE, FETCH, WAIT, STREAM as a 2-bit localparam set) and the element-slice helper (index k -> bit offset 16k).
- No sub-module is needed. The FSM, counter and capture buffer are a single module of roughly 150 lines.

Test Plan:
- Reset and basic stream: after reset, load element k = 16'h0100+k into the output register. Pulse start with out_ready=1. Expect:
  - reg_read high for exactly 1 cycle.
  - out_valid 3 edges after start.
  - out_data sequence 0x0100..0x010F.
  - row/col (0,0)..(3,3).
  - out_last only on 0x010F.
  - done one cycle after that transfer.
- Backpressure: same data with out_ready toggled 1,0,0,1 repeating. Expect each element held stable while ready=0, no element dropped or duplicated, and 16 transfers total.
- Start while busy: pulse start again at elements 5 and 15 and in the done cycle. Expect no extra reg_read, a single done, and a normal sequence.
- Data isolation: during STREAM, change reg_data to all 0xFFFF. Expect the streamed values to stay the originally captured ones.
- Reset mid-stream: assert reset at element 7. Expect out_valid, busy, done and reg_read all 0 immediately. A new start after reset streams from element 0.
- Back-to-back: start in the cycle after done. Expect a second complete stream with a fresh reg_read.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix output path: element geometry, streamer
// state encoding and the element-index to bit-offset helper.
package matrix_pkg;

   localparam int ELEM_W   = 16;
   localparam int DIM      = 4;
   localparam int NUM_ELEM = DIM * DIM;
   localparam int MAT_W    = ELEM_W * NUM_ELEM;
   localparam int K_W      = $clog2(NUM_ELEM);
   localparam int IDX_W    = $clog2(DIM);
   localparam int OFF_W    = $clog2(MAT_W);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_WAIT   = 2'd2,
      S_STREAM = 2'd3
   } state_e;

   // Element k of the packed matrix word starts at bit ELEM_W*k.
   function automatic logic [OFF_W-1:0] elem_off(input logic [K_W-1:0] k);
      return OFF_W'(k) * OFF_W'(ELEM_W);
   endfunction

endpackage

// File: rtl/matrix_out_streamer.sv
// Reads the 4x4 result matrix from the output register once per start and
// streams its elements row-major over a valid/ready element interface.
module matrix_out_streamer
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              reg_read,
   input  logic [MAT_W-1:0]  reg_data,
   output logic [ELEM_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [IDX_W-1:0]  out_row,
   output logic [IDX_W-1:0]  out_col,
   output logic              busy,
   output logic              done
);

   state_e             state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [MAT_W-1:0]   cap_q, cap_d;
   logic               done_q, done_d;
   logic               last_elem;

   assign last_elem = (k_q == K_W'(NUM_ELEM - 1));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cap_d   = cap_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A start coinciding with the done pulse belongs to the finished stream.
            if (start && !done_q) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cap_d   = reg_data;
            k_d     = '0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (out_ready) begin
               if (last_elem) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  k_d = k_q + K_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cap_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cap_q   <= cap_d;
         done_q  <= done_d;
      end
   end

   // Element outputs are forced to zero outside STREAM so idle cycles show no stale data.
   assign out_valid = (state_q == S_STREAM);
   assign reg_read  = (state_q == S_FETCH);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign out_data  = out_valid ? cap_q[elem_off(k_q) +: ELEM_W] : '0;
   assign out_row   = out_valid ? k_q[K_W-1 -: IDX_W] : '0;
   assign out_col   = out_valid ? k_q[IDX_W-1:0] : '0;
   assign out_last  = out_valid && last_elem;

endmodule

// File: tb/tb_matrix_out_streamer.sv
// Directed bench for matrix_out_streamer: latency, ordering, backpressure,
// ignored starts, capture isolation, mid-stream reset and back-to-back runs.
module tb_matrix_out_streamer;
   import matrix_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              reg_read;
   logic [MAT_W-1:0]  reg_data;
   logic [ELEM_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [1:0]        out_row;
   logic [1:0]        out_col;
   logic              busy;
   logic              done;

   int errors = 0;
   int checks = 0;
   int rr_cnt = 0;

   logic [15:0] got_data [16];
   logic [1:0]  got_row  [16];
   logic [1:0]  got_col  [16];
   logic        got_last [16];
   int n_xfer, done_cnt, hold_bad, timed_out, last_cyc, done_cyc, busy_at_done;

   matrix_out_streamer dut (
      .clk(clk), .reset(reset), .start(start), .reg_read(reg_read),
      .reg_data(reg_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_row(out_row),
      .out_col(out_col), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (reg_read === 1'b1) rr_cnt++;

   task automatic load_matrix(input logic [15:0] base);
      for (int k = 0; k < 16; k++) reg_data[16*k +: 16] = base + 16'(k);
   endtask

   task automatic pulse_start;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Drives out_ready / start around a running stream and records what it sees.
   task automatic collect(input bit bp, input logic [16:0] smask, input int corrupt_at, input bit b2b);
      int c = 0;
      int post = -1;
      bit held = 0;
      logic [15:0] hd;
      logic [1:0] hr, hc;
      logic hl;
      n_xfer = 0; done_cnt = 0; hold_bad = 0; timed_out = 1;
      last_cyc = -1; done_cyc = -1; busy_at_done = -1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         start = 1'b0;
         if (held && (out_valid !== 1'b1 || out_data !== hd || out_row !== hr ||
                      out_col !== hc || out_last !== hl)) hold_bad++;
         held = 0;
         if (done === 1'b1) begin
            done_cnt++;
            if (smask[16]) start = 1'b1;
         end
         if (post >= 0) post++;
         if (done === 1'b1 && post < 0) begin
            post = 0; done_cyc = cyc; busy_at_done = int'(busy);
         end
         if (b2b && post == 1) start = 1'b1;
         if (post == (b2b ? 2 : 4)) begin
            start = 1'b0; timed_out = 0; break;
         end
         if (out_valid === 1'b1) begin
            if (corrupt_at == n_xfer) reg_data = {16{16'hFFFF}};
            if (n_xfer < 16 && smask[n_xfer]) start = 1'b1;
            out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            c++;
            if (out_ready) begin
               if (n_xfer < 16) begin
                  got_data[n_xfer] = out_data; got_row[n_xfer] = out_row;
                  got_col[n_xfer] = out_col;   got_last[n_xfer] = out_last;
               end
               n_xfer++;
               last_cyc = cyc;
            end else begin
               held = 1; hd = out_data; hr = out_row; hc = out_col; hl = out_last;
            end
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if ({out_valid, busy, done, reg_read, out_last} !== 5'b0 || out_data !== 16'h0 ||
          out_row !== 2'd0 || out_col !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b busy=%b done=%b rd=%b last=%b data=%h expected all 0",
                  out_valid, busy, done, reg_read, out_last, out_data);
      end
   endtask

   task automatic test_basic_stream;
      int rr0;
      load_matrix(16'h0100);
      out_ready = 1'b1;
      rr0 = rr_cnt;
      pulse_start;
      checks++;
      if (reg_read !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fetch_cycle: rd=%b busy=%b valid=%b expected 1 1 0", reg_read, busy, out_valid);
      end
      @(negedge clk);
      checks++;
      if (reg_read !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_cycle: rd=%b busy=%b valid=%b expected 0 1 0", reg_read, busy, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0100) begin
         errors++;
         $display("FAIL first_valid_latency: valid=%b data=%h expected 1 0100", out_valid, out_data);
      end
      collect(1'b0, 17'h0, -1, 1'b0);
      checks++;
      if (timed_out != 0 || n_xfer != 16 || done_cnt != 1) begin
         errors++;
         $display("FAIL basic_counts: timeout=%0d xfers=%0d dones=%0d expected 0 16 1", timed_out, n_xfer, done_cnt);
      end
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (got_data[k] !== 16'h0100 + 16'(k) || got_row[k] !== 2'(k / 4) ||
             got_col[k] !== 2'(k % 4) || got_last[k] !== (k == 15)) begin
            errors++;
            $display("FAIL basic_elem%0d: data=%h row=%0d col=%0d last=%b expected %h %0d %0d %b",
                     k, got_data[k], got_row[k], got_col[k], got_last[k],
                     16'h0100 + 16'(k), k / 4, k % 4, k == 15);
         end
      end
      checks++;
      if (done_cyc - last_cyc != 1 || busy_at_done != 0) begin
         errors++;
         $display("FAIL done_timing: done_after=%0d busy_at_done=%0d expected 1 0", done_cyc - last_cyc, busy_at_done);
      end
      checks++;
      if (rr_cnt - rr0 != 1) begin
         errors++;
         $display("FAIL basic_reg_read: count=%0d expected 1", rr_cnt - rr0);
      end
   endtask

   task automatic test_backpressure;
      int bad = 0;
      load_matrix(16'h0100);
      pulse_start;
      collect(1'b1, 17'h0, -1, 1'b0);
      checks++;
      if (timed_out != 0 || n_xfer != 16 || done_cnt != 1 || hold_bad != 0) begin
         errors++;
         $display("FAIL bp_counts: timeout=%0d xfers=%0d dones=%0d hold_violations=%0d expected 0 16 1 0",
                  timed_out, n_xfer, done_cnt, hold_bad);
      end
      for (int k = 0; k < 16; k++)
         if (got_data[k] !== 16'h0100 + 16'(k) || got_last[k] !== (k == 15)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_sequence: bad_elements=%0d expected 0", bad);
      end
   endtask

   task automatic test_start_while_busy;
      int rr0, bad = 0;
      load_matrix(16'h0100);
      rr0 = rr_cnt;
      pulse_start;
      collect(1'b0, 17'h18020, -1, 1'b0);
      for (int k = 0; k < 16; k++) if (got_data[k] !== 16'h0100 + 16'(k)) bad++;
      checks++;
      if (rr_cnt - rr0 != 1 || done_cnt != 1 || n_xfer != 16 || bad != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_while_busy: reads=%0d dones=%0d xfers=%0d bad=%0d busy=%b expected 1 1 16 0 0",
                  rr_cnt - rr0, done_cnt, n_xfer, bad, busy);
      end
   endtask

   task automatic test_data_isolation;
      int bad = 0;
      load_matrix(16'h0200);
      pulse_start;
      collect(1'b0, 17'h0, 3, 1'b0);
      for (int k = 0; k < 16; k++) if (got_data[k] !== 16'h0200 + 16'(k)) bad++;
      checks++;
      if (bad != 0 || n_xfer != 16 || reg_data[15:0] !== 16'hFFFF) begin
         errors++;
         $display("FAIL data_isolation: bad=%0d xfers=%0d elem3=%h expected 0 16 0203",
                  bad, n_xfer, got_data[3]);
      end
   endtask

   task automatic test_reset_mid_stream;
      int rr0, found = 0;
      load_matrix(16'h0100);
      out_ready = 1'b1;
      pulse_start;
      for (int i = 0; i < 30; i++) begin
         if (out_valid === 1'b1 && out_data === 16'h0107) begin found = 1; break; end
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (found != 1 || {out_valid, busy, done, reg_read} !== 4'b0 || out_data !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid_stream: reached7=%0d valid=%b busy=%b done=%b rd=%b data=%h expected 1 0 0 0 0 0",
                  found, out_valid, busy, done, reg_read, out_data);
      end
      @(negedge clk); reset = 1'b0;
      rr0 = rr_cnt;
      repeat (3) @(negedge clk);
      checks++;
      if (rr_cnt != rr0 || out_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_idle: reads=%0d valid=%b done=%b expected 0 0 0", rr_cnt - rr0, out_valid, done);
      end
      pulse_start;
      collect(1'b0, 17'h0, -1, 1'b0);
      checks++;
      if (n_xfer != 16 || got_data[0] !== 16'h0100 || got_data[15] !== 16'h010F || done_cnt != 1) begin
         errors++;
         $display("FAIL restream_after_reset: xfers=%0d first=%h last=%h dones=%0d expected 16 0100 010F 1",
                  n_xfer, got_data[0], got_data[15], done_cnt);
      end
   endtask

   task automatic test_back_to_back;
      int rr0, bad = 0;
      load_matrix(16'h0300);
      rr0 = rr_cnt;
      pulse_start;
      collect(1'b0, 17'h0, -1, 1'b1);
      checks++;
      if (n_xfer != 16 || got_data[15] !== 16'h030F || done_cnt != 1) begin
         errors++;
         $display("FAIL b2b_first: xfers=%0d last=%h dones=%0d expected 16 030F 1", n_xfer, got_data[15], done_cnt);
      end
      load_matrix(16'h0400);
      collect(1'b0, 17'h0, -1, 1'b0);
      for (int k = 0; k < 16; k++) if (got_data[k] !== 16'h0400 + 16'(k)) bad++;
      checks++;
      if (timed_out != 0 || n_xfer != 16 || bad != 0 || done_cnt != 1 || rr_cnt - rr0 != 2) begin
         errors++;
         $display("FAIL b2b_second: timeout=%0d xfers=%0d bad=%0d dones=%0d reads=%0d expected 0 16 0 1 2",
                  timed_out, n_xfer, bad, done_cnt, rr_cnt - rr0);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; reg_data = '0;
      repeat (2) @(negedge clk);
      test_reset;
      reset = 1'b0;
      @(negedge clk);
      test_basic_stream;
      test_backpressure;
      test_start_while_busy;
      test_data_isolation;
      test_reset_mid_stream;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
